mdio_responder: RTL and testbench

Clause-22 MDIO management responder (PHY side) that answers frames issued by the Ethernet MAC's MDC/MDIO master. It oversamples MDC and MDIO in the system clock domain and decodes read and write frames addressed to its PHY address. It exposes a simple register-bank strobe interface and drives MDIO through a separate output and output-enable pair, so the top level builds the tri-state pad. It is used as an on-chip PHY management emulator and as the bench counterpart for the MAC's MDIO master.

---
 rtl/mdio_pkg.sv | 24 ++
 rtl/mdio_edge_sync.sv | 39 +++
 rtl/mdio_responder.sv | 224 ++++++++++++++++++++++
 tb/tb_mdio_responder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mdio_pkg.sv
// Shared types and constants for the Clause-22 MDIO responder.
package mdio_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ST2,
        OP,
        PHYAD,
        REGAD,
        TA,
        RDATA,
        WDATA
    } state_t;

    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b01;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 16;

    // Wide enough to count 0..DATA_W
    localparam int unsigned CNT_W  = 5;

endpackage

// File: rtl/mdio_edge_sync.sv
// Synchronises mdc and mdio_i into clk and produces one-clk mdc edge pulses.
module mdio_edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic mdc,
    input  logic mdio_i,
    output logic mdio_s,
    output logic mdc_rise,
    output logic mdc_fall
);

    logic [SYNC_STAGES-1:0] mdc_sync;
    logic [SYNC_STAGES-1:0] mdio_sync;
    logic                   mdc_prev;

    // Equal-depth chains keep mdio aligned with the mdc edge it belongs to
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mdc_sync  <= '0;
            mdio_sync <= '0;
            mdc_prev  <= 1'b0;
        end else begin
            mdc_sync[0]  <= mdc;
            mdio_sync[0] <= mdio_i;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                mdc_sync[i]  <= mdc_sync[i-1];
                mdio_sync[i] <= mdio_sync[i-1];
            end
            mdc_prev <= mdc_sync[SYNC_STAGES-1];
        end
    end

    assign mdio_s   = mdio_sync[SYNC_STAGES-1];
    assign mdc_rise =  mdc_sync[SYNC_STAGES-1] & ~mdc_prev;
    assign mdc_fall = ~mdc_sync[SYNC_STAGES-1] &  mdc_prev;

endmodule

// File: rtl/mdio_responder.sv
// Clause-22 MDIO responder: decodes MAC frames and drives a register-bank strobe port.
module mdio_responder
    import mdio_pkg::*;
#(
    parameter logic [ADDR_W-1:0] PHY_ADDR      = 5'd1,
    parameter int unsigned       PREAMBLE_BITS = 32,
    parameter int unsigned       SYNC_STAGES   = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              mdc,
    input  logic              mdio_i,
    output logic              mdio_o,
    output logic              mdio_oe,
    output logic [ADDR_W-1:0] reg_addr,
    output logic              reg_rd,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic              reg_wr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              busy,
    output logic              frame_err
);

    localparam int unsigned PCNT_W = $clog2(PREAMBLE_BITS + 1);

    logic mdio_s, mdc_rise, mdc_fall;

    mdio_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .mdc      (mdc),
        .mdio_i   (mdio_i),
        .mdio_s   (mdio_s),
        .mdc_rise (mdc_rise),
        .mdc_fall (mdc_fall)
    );

    state_t              state_q, state_d;
    logic [PCNT_W-1:0]   pre_cnt_q, pre_cnt_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic                is_read_q, is_read_d;
    logic                match_q, match_d;
    logic                ta_first_q, ta_first_d;
    logic [ADDR_W-1:0]   addr_sh_q, addr_sh_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                oe_q, oe_d, o_q, o_d;
    logic                rd_q, rd_d, rd_late_q, rd_late_d;
    logic                wr_q, wr_d, err_q, err_d;
    logic [ADDR_W-1:0]   sh_in;

    assign sh_in = {addr_sh_q[ADDR_W-2:0], mdio_s};

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            pre_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            is_read_q  <= 1'b0;
            match_q    <= 1'b0;
            ta_first_q <= 1'b0;
            addr_sh_q  <= '0;
            addr_q     <= '0;
            shift_q    <= '0;
            oe_q       <= 1'b0;
            o_q        <= 1'b0;
            rd_q       <= 1'b0;
            rd_late_q  <= 1'b0;
            wr_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_cnt_q  <= pre_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            is_read_q  <= is_read_d;
            match_q    <= match_d;
            ta_first_q <= ta_first_d;
            addr_sh_q  <= addr_sh_d;
            addr_q     <= addr_d;
            shift_q    <= shift_d;
            oe_q       <= oe_d;
            o_q        <= o_d;
            rd_q       <= rd_d;
            rd_late_q  <= rd_late_d;
            wr_q       <= wr_d;
            err_q      <= err_d;
        end
    end

    // Frame decode: fields sampled on mdc rise, read data driven on mdc fall
    always_comb begin
        state_d    = state_q;
        pre_cnt_d  = pre_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        is_read_d  = is_read_q;
        match_d    = match_q;
        ta_first_d = ta_first_q;
        addr_sh_d  = addr_sh_q;
        addr_d     = addr_q;
        shift_d    = shift_q;
        oe_d       = oe_q;
        o_d        = o_q;
        rd_d       = 1'b0;
        rd_late_d  = rd_q;
        wr_d       = 1'b0;
        err_d      = 1'b0;

        // Register bank answers one clk after the strobe
        if (rd_late_q) shift_d = reg_rdata;

        unique case (state_q)
            IDLE: if (mdc_rise) begin
                if (mdio_s) begin
                    if (pre_cnt_q != PCNT_W'(PREAMBLE_BITS)) pre_cnt_d = pre_cnt_q + PCNT_W'(1);
                end else begin
                    if (pre_cnt_q == PCNT_W'(PREAMBLE_BITS)) state_d = ST2;
                    pre_cnt_d = '0;
                end
            end
            ST2: if (mdc_rise) begin
                if (mdio_s) begin
                    state_d   = OP;
                    bit_cnt_d = '0;
                end else begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            OP: if (mdc_rise) begin
                addr_sh_d = sh_in;
                if (bit_cnt_q == '0) begin
                    bit_cnt_d = CNT_W'(1);
                end else begin
                    bit_cnt_d = '0;
                    state_d   = PHYAD;
                    if ({addr_sh_q[0], mdio_s} == OP_READ) begin
                        is_read_d = 1'b1;
                    end else if ({addr_sh_q[0], mdio_s} == OP_WRITE) begin
                        is_read_d = 1'b0;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            PHYAD: if (mdc_rise) begin
                addr_sh_d = sh_in;
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                if (bit_cnt_q == CNT_W'(ADDR_W - 1)) begin
                    match_d   = (sh_in == PHY_ADDR);
                    bit_cnt_d = '0;
                    state_d   = REGAD;
                end
            end
            REGAD: if (mdc_rise) begin
                addr_sh_d = sh_in;
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                if (bit_cnt_q == CNT_W'(ADDR_W - 1)) begin
                    addr_d    = sh_in;
                    rd_d      = is_read_q & match_q;
                    bit_cnt_d = '0;
                    state_d   = TA;
                end
            end
            TA: begin
                if (mdc_rise) begin
                    if (bit_cnt_q == '0) begin
                        ta_first_d = mdio_s;
                        bit_cnt_d  = CNT_W'(1);
                    end else begin
                        bit_cnt_d = '0;
                        if (match_q && !is_read_q && !(ta_first_q && !mdio_s)) begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end else if (match_q && is_read_q) begin
                            state_d = RDATA;
                        end else begin
                            state_d = WDATA;
                        end
                    end
                end else if (mdc_fall && bit_cnt_q == CNT_W'(1) && match_q && is_read_q) begin
                    oe_d = 1'b1;
                    o_d  = 1'b0;
                end
            end
            // Counts falls only: 16 falls present D15..D0, the 17th follows the D0 rise
            RDATA: if (mdc_fall) begin
                if (bit_cnt_q == CNT_W'(DATA_W)) begin
                    oe_d    = 1'b0;
                    o_d     = 1'b0;
                    state_d = IDLE;
                end else begin
                    o_d       = shift_q[DATA_W-1];
                    shift_d   = {shift_q[DATA_W-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            // Also sinks the data phase of unmatched frames, with the strobe gated off
            WDATA: if (mdc_rise) begin
                shift_d   = {shift_q[DATA_W-2:0], mdio_s};
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                    wr_d      = match_q & ~is_read_q;
                    bit_cnt_d = '0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mdio_o    = o_q;
    assign mdio_oe   = oe_q;
    assign reg_addr  = addr_q;
    assign reg_rd    = rd_q;
    assign reg_wr    = wr_q;
    assign reg_wdata = shift_q;
    assign frame_err = err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mdio_responder.sv
// Randomised frame-level bench for mdio_responder against a protocol reference model.
module tb_mdio_responder;

    localparam logic [4:0] PHY = 5'd1;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        mdc = 1'b0;
    logic        mdio_i;
    logic        mdio_o, mdio_oe;
    logic [4:0]  reg_addr;
    logic        reg_rd, reg_wr;
    logic [15:0] reg_rdata;
    logic [15:0] reg_wdata;
    logic        busy, frame_err;

    // MAC side of the shared pad; undriven bus is pulled up
    logic mac_oe = 1'b1;
    logic mac_val = 1'b1;
    assign mdio_i = mdio_oe ? mdio_o : (mac_oe ? mac_val : 1'b1);

    mdio_responder #(
        .PHY_ADDR      (PHY),
        .PREAMBLE_BITS (32),
        .SYNC_STAGES   (2)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .mdc       (mdc),
        .mdio_i    (mdio_i),
        .mdio_o    (mdio_o),
        .mdio_oe   (mdio_oe),
        .reg_addr  (reg_addr),
        .reg_rd    (reg_rd),
        .reg_rdata (reg_rdata),
        .reg_wr    (reg_wr),
        .reg_wdata (reg_wdata),
        .busy      (busy),
        .frame_err (frame_err)
    );

    always #10 clk = ~clk;

    function automatic logic [15:0] init_val(input int i);
        return (i == 2) ? 16'h0022 : 16'((i * 16'h1111) ^ 16'hA5A5);
    endfunction

    // Register bank behind the strobe port, one-clk read latency
    logic [15:0] bank [32];
    always @(posedge clk) reg_rdata <= bank[reg_addr];

    int wr_cnt = 0, rd_cnt = 0, err_cnt = 0, both_cnt = 0, oe_cnt = 0;
    logic [4:0]  wr_addr, rd_addr;
    logic [15:0] wr_data;

    // Strobe monitor, sampled away from the active edge
    initial begin
        for (int i = 0; i < 32; i++) bank[i] = init_val(i);
        forever begin
            @(negedge clk);
            if (reg_wr) begin
                wr_cnt++;
                wr_addr = reg_addr;
                wr_data = reg_wdata;
                bank[reg_addr] = reg_wdata;
            end
            if (reg_rd) begin
                rd_cnt++;
                rd_addr = reg_addr;
            end
            if (frame_err) err_cnt++;
            if (reg_rd && reg_wr) both_cnt++;
            if (mdio_oe) oe_cnt++;
        end
    end

    int vectors = 0, miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [15:0] mregs [32];

    // One MDC period; MAC samples the bus just before raising MDC
    task automatic mdc_bit(input logic drv, input logic val, output logic smp);
        mac_oe  = drv;
        mac_val = val;
        #200;
        smp = mdio_i;
        mdc = 1'b1;
        #200;
        mdc = 1'b0;
    endtask

    task automatic run_frame(input int npre, input logic st2, input logic [1:0] op,
                             input logic [4:0] phy, input logic [4:0] ra,
                             input logic [1:0] ta, input logic [15:0] wd, input int rst_bit);
        int          wr0, rd0, err0, both0, oe0;
        logic        accepted, hdr_ok, match, exp_wr, exp_rd, exp_err, is_rd, smp, aborted;
        logic [15:0] exp_rdata;
        logic [17:0] rx;
        logic [4:0]  fld;

        wr0 = wr_cnt; rd0 = rd_cnt; err0 = err_cnt; both0 = both_cnt; oe0 = oe_cnt;

        // Reference: what a Clause-22 PHY must do with this frame
        accepted  = (npre >= 32);
        hdr_ok    = accepted && st2 && (op == 2'b10 || op == 2'b01);
        match     = (phy == PHY);
        exp_rd    = hdr_ok && match && (op == 2'b10);
        exp_wr    = hdr_ok && match && (op == 2'b01) && (ta == 2'b10);
        exp_err   = (accepted && !hdr_ok) || (hdr_ok && match && op == 2'b01 && ta != 2'b10);
        exp_rdata = mregs[ra];
        if (exp_wr) mregs[ra] = wd;

        for (int i = 0; i < npre; i++) mdc_bit(1'b1, 1'b1, smp);
        mdc_bit(1'b1, 1'b0, smp);
        mdc_bit(1'b1, st2, smp);
        mdc_bit(1'b1, op[1], smp);
        mdc_bit(1'b1, op[0], smp);
        fld = phy;
        for (int i = 4; i >= 0; i--) mdc_bit(1'b1, fld[i], smp);
        fld = ra;
        for (int i = 4; i >= 0; i--) mdc_bit(1'b1, fld[i], smp);
        check("busy_after_header", 32'(busy), 32'(hdr_ok));

        is_rd   = (op == 2'b10);
        aborted = 1'b0;
        rx      = '0;
        for (int i = 0; i < 18 && !aborted; i++) begin
            if (rst_bit >= 0 && i == rst_bit + 2) begin
                #100;
                check("rst_oe_before", 32'(mdio_oe), 32'(exp_rd));
                @(negedge clk);
                reset_n = 1'b0;
                @(posedge clk);
                #1;
                check("rst_oe", 32'(mdio_oe), 32'd0);
                check("rst_busy", 32'(busy), 32'd0);
                repeat (3) @(posedge clk);
                @(negedge clk);
                reset_n = 1'b1;
                mac_oe  = 1'b1;
                mac_val = 1'b1;
                aborted = 1'b1;
            end else begin
                mdc_bit(!is_rd, (i < 2) ? ta[1 - i] : wd[17 - i], smp);
                rx = {rx[16:0], smp};
            end
        end
        mac_oe  = 1'b1;
        mac_val = 1'b1;

        repeat (20) @(posedge clk);
        #1;
        check("rd_strobes", 32'(rd_cnt - rd0), 32'(exp_rd));
        check("wr_strobes", 32'(wr_cnt - wr0), aborted ? 32'd0 : 32'(exp_wr));
        check("frame_err", 32'(err_cnt - err0), aborted ? 32'd0 : 32'(exp_err));
        check("rd_wr_overlap", 32'(both_cnt - both0), 32'd0);
        check("busy_end", 32'(busy), 32'd0);
        check("oe_end", 32'(mdio_oe), 32'd0);
        if (!aborted) begin
            check("oe_used", 32'(oe_cnt != oe0), 32'(exp_rd));
            if (exp_wr) begin
                check("wr_addr", 32'(wr_addr), 32'(ra));
                check("wr_data", 32'(wr_data), 32'(wd));
            end
            if (exp_rd) begin
                check("rd_addr", 32'(rd_addr), 32'(ra));
                check("rd_ta2", 32'(rx[16]), 32'd0);
                check("rd_data", 32'(rx[15:0]), 32'(exp_rdata));
            end
        end

        // A lone 0 with a short count leaves the preamble counter at 0 for the next frame
        mdc_bit(1'b1, 1'b0, smp);
        repeat (5) @(posedge clk);
    endtask

    initial begin
        int          npre, sel;
        logic        st2;
        logic [1:0]  op, ta;
        logic [4:0]  phy, ra;

        for (int i = 0; i < 32; i++) mregs[i] = init_val(i);

        repeat (5) @(posedge clk);
        #1;
        check("reset_oe", 32'(mdio_oe), 32'd0);
        check("reset_o", 32'(mdio_o), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_strobes", {29'd0, reg_rd, reg_wr, frame_err}, 32'd0);
        check("reset_addr", 32'(reg_addr), 32'd0);
        check("reset_wdata", 32'(reg_wdata), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(posedge clk);

        run_frame(32, 1'b1, 2'b01, 5'd1, 5'd4, 2'b10, 16'h01E1, -1);
        run_frame(32, 1'b1, 2'b10, 5'd1, 5'd2, 2'b10, 16'h0000, -1);
        run_frame(32, 1'b1, 2'b10, 5'd3, 5'd2, 2'b10, 16'h0000, -1);
        run_frame(31, 1'b1, 2'b01, 5'd1, 5'd6, 2'b10, 16'hBEEF, -1);
        run_frame(32, 1'b1, 2'b01, 5'd1, 5'd6, 2'b10, 16'hBEEF, -1);
        run_frame(32, 1'b1, 2'b00, 5'd1, 5'd6, 2'b10, 16'h1234, -1);
        run_frame(32, 1'b1, 2'b10, 5'd1, 5'd6, 2'b10, 16'h0000, -1);
        run_frame(32, 1'b1, 2'b10, 5'd1, 5'd4, 2'b10, 16'h0000, 7);
        run_frame(32, 1'b1, 2'b10, 5'd1, 5'd4, 2'b10, 16'h0000, -1);

        for (int n = 0; n < 22; n++) begin
            npre = ($urandom_range(0, 3) == 0) ? int'($urandom_range(28, 31)) : int'($urandom_range(32, 36));
            st2  = ($urandom_range(0, 9) != 0);
            sel  = int'($urandom_range(0, 7));
            op   = (sel < 3) ? 2'b10 : (sel < 6) ? 2'b01 : (sel == 6) ? 2'b00 : 2'b11;
            phy  = ($urandom_range(0, 3) != 0) ? PHY : 5'($urandom_range(0, 31));
            ra   = 5'($urandom_range(0, 31));
            ta   = ($urandom_range(0, 7) != 0) ? 2'b10 : 2'($urandom_range(0, 3));
            run_frame(npre, st2, op, phy, ra, ta, 16'($urandom), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
